// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, init ROM, status and write-word field positions for lcd_ctrl
package lcd_pkg;
  typedef enum logic [2:0] {PWR_WAIT, INIT_LOAD, IDLE, SETUP, EN_HIGH, HOLD, EXEC_WAIT} state_t;
  localparam logic [1:0] INIT_LAST = 2'd3;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_INIT = 3;
  localparam int ST_CNT = 4;
  localparam int WR_RS = 8;
  localparam int WR_CLR = 31;
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    return idx == 2'd0 ? 8'h38 : idx == 2'd1 ? 8'h0C : idx == 2'd2 ? 8'h01 : 8'h06;
  endfunction
  // clear (0x01) and home (0x02/0x03) are the only commands needing the long wait
  function automatic logic is_slow(input logic rs, input logic [7:0] b);
    return !rs && b[7:2] == 6'd0;
  endfunction
  function automatic int max_of(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: small synchronous command FIFO; push and pop may coincide even when full
module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + AW'(1);
      if (pop_i) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wp_q] <= data_i;
  end
  assign data_o = mem_q[rp_q];
  assign count_o = cnt_q;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-style LCD controller; queues LSU writes, runs power-on init,
// and replays each byte with setup / enable / hold / execution timing.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int T_AS = 2,
  parameter int T_EN = 12,
  parameter int T_HOLD = 2,
  parameter int T_EXEC = 1850,
  parameter int T_CLEAR = 76000,
  parameter int T_PWR = 750000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] status_o,
  output logic [7:0]       lcd_data_o,
  output logic             lcd_rs_o,
  output logic             lcd_rw_o,
  output logic             lcd_en_o,
  output logic             lcd_on_o
);
  localparam int TMAX = max_of(max_of(max_of(T_AS, T_EN), max_of(T_HOLD, T_EXEC)), max_of(T_CLEAR, T_PWR));
  localparam int CW = $clog2(TMAX) + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  function automatic logic [CW-1:0] ld(input int n);
    return CW'(n - 1);
  endfunction
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic done_q, done_d, rs_q, rs_d, ovf_q, ovf_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] lcd_data_q;
  logic lcd_rs_q, lcd_en_q, lcd_on_q;
  logic [WIDTH-1:0] status_q, status_d;
  logic push, pop, wr_cmd, f_full, f_empty, cnt_zero;
  logic [8:0] f_data;
  logic [FCW-1:0] f_count;
  logic unused_wr;
  assign unused_wr = ^wr_data_i[WR_CLR-1:WR_RS+1];
  assign cnt_zero = cnt_q == '0;
  assign wr_cmd = wr_en_i && !wr_data_i[WR_CLR];
  assign push = wr_cmd && (!f_full || pop);
  // queued bytes only leave once init is done; EXEC_WAIT chains straight into the next byte
  assign pop = !f_empty && done_q && (state_q == IDLE || (state_q == EXEC_WAIT && cnt_zero));
  assign ovf_d = (wr_en_i && wr_data_i[WR_CLR]) ? 1'b0 : (wr_cmd && f_full && !pop) ? 1'b1 : ovf_q;
  lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push_i(push),
    .pop_i(pop),
    .data_i(wr_data_i[WR_RS:0]),
    .data_o(f_data),
    .count_o(f_count),
    .full_o(f_full),
    .empty_o(f_empty)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_zero ? cnt_q : cnt_q - CW'(1);
    idx_d = idx_q;
    done_d = done_q;
    cmd_d = cmd_q;
    rs_d = rs_q;
    unique case (state_q)
      PWR_WAIT: state_d = cnt_zero ? INIT_LOAD : PWR_WAIT;
      INIT_LOAD: begin
        cmd_d = init_byte(idx_q);
        rs_d = 1'b0;
        state_d = SETUP;
        cnt_d = ld(T_AS);
      end
      IDLE: state_d = IDLE;
      SETUP: if (cnt_zero) begin
        state_d = EN_HIGH;
        cnt_d = ld(T_EN);
      end
      EN_HIGH: if (cnt_zero) begin
        state_d = HOLD;
        cnt_d = ld(T_HOLD);
      end
      HOLD: if (cnt_zero) begin
        state_d = EXEC_WAIT;
        cnt_d = is_slow(rs_q, cmd_q) ? ld(T_CLEAR) : ld(T_EXEC);
      end
      EXEC_WAIT: if (cnt_zero) begin
        state_d = (done_q || idx_q == INIT_LAST) ? IDLE : INIT_LOAD;
        done_d = done_q || idx_q == INIT_LAST;
        idx_d = (done_q || idx_q == INIT_LAST) ? idx_q : idx_q + 2'd1;
      end
      default: state_d = PWR_WAIT;
    endcase
    if (pop) begin
      cmd_d = f_data[7:0];
      rs_d = f_data[WR_RS];
      state_d = SETUP;
      cnt_d = ld(T_AS);
    end
  end
  always_comb begin
    status_d = '0;
    status_d[ST_BUSY] = state_q != IDLE || !f_empty;
    status_d[ST_FULL] = f_full;
    status_d[ST_OVF] = ovf_q;
    status_d[ST_INIT] = done_q;
    status_d[ST_CNT +: 3] = 3'(f_count);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= PWR_WAIT;
      cnt_q <= ld(T_PWR);
      idx_q <= '0;
      done_q <= 1'b0;
      cmd_q <= '0;
      rs_q <= 1'b0;
      ovf_q <= 1'b0;
      lcd_data_q <= '0;
      lcd_rs_q <= 1'b0;
      lcd_en_q <= 1'b0;
      lcd_on_q <= 1'b0;
      status_q <= WIDTH'(1);
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      done_q <= done_d;
      cmd_q <= cmd_d;
      rs_q <= rs_d;
      ovf_q <= ovf_d;
      lcd_data_q <= cmd_q;
      lcd_rs_q <= rs_q;
      lcd_en_q <= state_q == EN_HIGH;
      lcd_on_q <= 1'b1;
      status_q <= status_d;
    end
  end
  assign status_o = status_q;
  assign lcd_data_o = lcd_data_q;
  assign lcd_rs_o = lcd_rs_q;
  assign lcd_rw_o = 1'b0;
  assign lcd_en_o = lcd_en_q;
  assign lcd_on_o = lcd_on_q;
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: scoreboard bench; stimulus queues expected LCD bytes, a monitor checks
// each EN pulse (data, RS, width, spacing from the previous pulse).
module tb_lcd_ctrl;
  localparam int T_PWR = 10;
  localparam int T_AS = 2;
  localparam int T_EN = 3;
  localparam int T_HOLD = 1;
  localparam int T_EXEC = 5;
  localparam int T_CLEAR = 20;
  localparam int OCC = T_AS + T_EN + T_HOLD;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0;
  logic [31:0] wr_data = '0, status;
  logic [7:0] lcd_data;
  logic lcd_rs, lcd_rw, lcd_en, lcd_on;
  typedef struct {
    logic rs;
    logic [7:0] data;
    int gap;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, cyc = 0, last_rise = 0, width = 0;
  logic en_prev = 1'b0;
  lcd_ctrl #(.T_AS(T_AS), .T_EN(T_EN), .T_HOLD(T_HOLD), .T_EXEC(T_EXEC),
             .T_CLEAR(T_CLEAR), .T_PWR(T_PWR)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data), .status_o(status),
    .lcd_data_o(lcd_data), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw), .lcd_en_o(lcd_en), .lcd_on_o(lcd_on)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic wr(input logic [31:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(posedge clk);
    #2;
    wr_en = 1'b0;
  endtask
  task automatic expect_byte(input logic rs, input logic [7:0] d, input int gap);
    exp_t e;
    e.rs = rs;
    e.data = d;
    e.gap = gap;
    sb.push_back(e);
  endtask
  task automatic wait_idle;
    int n;
    n = 0;
    @(negedge clk);
    while (n < 400 && status[0]) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(status[0]), 0);
    check("sb_drained", sb.size(), 0);
  endtask
  task automatic power_up;
    int n;
    expect_byte(1'b0, 8'h38, 0);
    expect_byte(1'b0, 8'h0C, OCC + T_EXEC + 1);
    expect_byte(1'b0, 8'h01, OCC + T_EXEC + 1);
    expect_byte(1'b0, 8'h06, OCC + T_CLEAR + 1);
    rst = 1'b0;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) check("lcd_on", 32'(lcd_on), 1);
      if (lcd_en) break;
    end
    // power wait, one INIT_LOAD cycle, setup, then the output register
    check("pwr_wait_edges", n, T_PWR + 1 + T_AS + 1);
    n = 0;
    while (n < 400 && !status[3]) begin
      @(negedge clk);
      n++;
    end
    check("init_done", 32'(status[3]), 1);
    check("post_init_status", status, 32'h8);
    check("init_sb_drained", sb.size(), 0);
  endtask
  always @(negedge clk) begin
    if (rst) begin
      en_prev = 1'b0;
      width = 0;
    end else begin
      if (lcd_en && !en_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got data %0h rs %0b, no byte expected", lcd_data, lcd_rs);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("bus_data", lcd_data, e.data);
          check("bus_rs", 32'(lcd_rs), 32'(e.rs));
          check("bus_rw", 32'(lcd_rw), 0);
          if (e.gap != 0) check("rise_gap", cyc - last_rise, e.gap);
        end
        last_rise = cyc;
        width = 1;
      end else if (lcd_en) width++;
      else if (en_prev) check("en_width", width, T_EN);
      en_prev = lcd_en;
    end
  end
  initial begin
    #50000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_status", status, 32'h1);
    check("rst_en", 32'(lcd_en), 0);
    check("rst_on", 32'(lcd_on), 0);
    check("rst_data", 32'(lcd_data), 0);
    check("rst_rs", 32'(lcd_rs), 0);
    step();
    power_up();
    // single data byte from idle
    step();
    expect_byte(1'b1, 8'h41, 0);
    wr(32'h141);
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (n == 1) check("count_after_write", 32'(status[6:4]), 1);
      if (n == 2) begin
        check("data_2edges", 32'(lcd_data), 32'h41);
        check("rs_2edges", 32'(lcd_rs), 1);
      end
      if (n > 0 && !status[0]) break;
      @(posedge clk);
      n++;
    end
    // pop edge + per-byte occupancy + status register lag
    check("busy_clear_edges", n, 1 + OCC + T_EXEC + 1);
    // clear command gets the long wait, data byte the short one
    step();
    expect_byte(1'b0, 8'h01, 0);
    expect_byte(1'b1, 8'h05, OCC + T_CLEAR);
    expect_byte(1'b1, 8'h41, OCC + T_EXEC);
    wr(32'h001);
    wr(32'h105);
    wr(32'h141);
    wait_idle();
    // overflow: one byte in flight, then five writes into a depth-4 queue
    step();
    expect_byte(1'b1, 8'h41, 0);
    wr(32'h141);
    repeat (3) step();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_byte(1'b1, 8'(8'h42 + i), OCC + T_EXEC);
      wr(32'h142 + 32'(i));
    end
    @(negedge clk);
    @(negedge clk);
    check("ovf_set", 32'(status[2]), 1);
    check("count_full", 32'(status[6:4]), 4);
    step();
    wr(32'h8000_0000);
    @(negedge clk);
    @(negedge clk);
    check("ovf_cleared", 32'(status[2]), 0);
    check("count_after_clr", 32'(status[6:4]), 4);
    // refill to full, then write exactly on the next pop edge
    step();
    expect_byte(1'b1, 8'h47, OCC + T_EXEC);
    wr(32'h147);
    repeat (8) step();
    expect_byte(1'b1, 8'h48, OCC + T_EXEC);
    wr(32'h148);
    @(negedge clk);
    @(negedge clk);
    check("count_push_pop_full", 32'(status[6:4]), 4);
    check("full_flag", 32'(status[1]), 1);
    check("no_ovf_on_pop", 32'(status[2]), 0);
    wait_idle();
    // asynchronous reset while EN is high, with a byte still queued
    step();
    expect_byte(1'b1, 8'h41, 0);
    wr(32'h141);
    wr(32'h142);
    n = 0;
    while (n < 50 && !lcd_en) begin
      @(negedge clk);
      n++;
    end
    check("en_before_reset", 32'(lcd_en), 1);
    step();
    rst = 1'b1;
    #1;
    check("async_rst_en", 32'(lcd_en), 0);
    check("async_rst_status", status, 32'h1);
    check("async_rst_data", 32'(lcd_data), 0);
    check("async_rst_on", 32'(lcd_on), 0);
    step();
    step();
    power_up();
    repeat (5) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
